// File: rtl/reg_load_sequencer.sv
// ---------------------------------------------------------------------------
// reg_load_sequencer
//
// Purpose:
//    Feeds the 7-entry register bank from a valid/ready word stream. One load
//    writes exactly N consecutive words into bank entries 1..N, one word per
//    accepted beat. It then pulses done once the whole bank holds new values.
//    The sel_reg code 0 means "no write", so the bank only updates on cycles
//    that follow an accepted word.
//
// Ports:
//    clk       in   1  clock, rising edge
//    rst       in   1  synchronous active-high reset
//    start     in   1  begin a load (only looked at in IDLE)
//    abort     in   1  cancel a load in progress (only looked at in LOAD)
//    in_valid  in   1  in_data carries a word
//    in_data   in   D  word to write
//    in_ready  out  1  a word is accepted this cycle if in_valid is also high
//    data      out  D  registered write data for the bank
//    sel_reg   out  A  registered write address for the bank, 0 = no write
//    busy      out  1  high in LOAD, LAST and DONE
//    done      out  1  one-cycle pulse, all N entries loaded
// ---------------------------------------------------------------------------
module reg_load_sequencer #(
   parameter int D = 7,
   parameter int A = 3,
   parameter int N = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic         in_valid,
   input  logic [D-1:0] in_data,
   output logic         in_ready,
   output logic [D-1:0] data,
   output logic [A-1:0] sel_reg,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_LAST = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [A-1:0] IDX_FIRST = A'(1);
   localparam logic [A-1:0] IDX_LAST  = A'(N);

   state_t         state_q, state_d;
   logic [A-1:0]   idx_q,   idx_d;
   logic [D-1:0]   data_q,  data_d;
   logic [A-1:0]   sel_q,   sel_d;
   logic           done_q,  done_d;
   logic           accept;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= IDX_FIRST;
         data_q  <= '0;
         sel_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         done_q  <= done_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         S_IDLE: begin
            // start wins even if abort is high in the same cycle
            if (start) begin
               state_d = S_LOAD;
               idx_d   = IDX_FIRST;
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (accept) begin
               // idx stays parked at N on the final word so it never
               // leaves the 1..N range
               if (idx_q == IDX_LAST) begin
                  state_d = S_LAST;
               end else begin
                  idx_d = idx_q + IDX_FIRST;
               end
            end
         end
         S_LAST: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State-decoded outputs
   // ------------------------------------------------------------------
   always_comb begin
      in_ready = (state_q == S_LOAD) && !abort;
      busy     = (state_q != S_IDLE);
      accept   = in_valid && in_ready;
   end

   // ------------------------------------------------------------------
   // Registered bank strobe, data and done
   // ------------------------------------------------------------------
   always_comb begin
      sel_d  = '0;
      data_d = data_q;   // data bus holds between strobes
      if (accept) begin
         sel_d  = idx_q;
         data_d = in_data;
      end
      // LAST carries the strobe for entry N; done follows one cycle later,
      // when the bank has captured that final word.
      done_d = (state_q == S_LAST);
   end

   assign data    = data_q;
   assign sel_reg = sel_q;
   assign done    = done_q;

endmodule

// File: tb/tb_reg_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reg_load_sequencer
//
// Purpose:
//    Directed self-checking bench for reg_load_sequencer. A behavioural bank
//    captures data at sel_reg on every strobe so bank contents can be read
//    back after each load. A second instance with N=1 covers the one-word
//    load.
// ---------------------------------------------------------------------------
module tb_reg_load_sequencer;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, abort, in_valid;
   logic [6:0] in_data;
   logic       in_ready, busy, done;
   logic [6:0] data;
   logic [2:0] sel_reg;

   logic       s1_start, s1_abort, s1_valid;
   logic [6:0] s1_data_in;
   logic       s1_ready, s1_busy, s1_done;
   logic [6:0] s1_data;
   logic [2:0] s1_sel;

   int errors = 0;
   int checks = 0;

   reg_load_sequencer #(.D(7), .A(3), .N(7)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .data     (data),
      .sel_reg  (sel_reg),
      .busy     (busy),
      .done     (done)
   );

   reg_load_sequencer #(.D(7), .A(3), .N(1)) dut_n1 (
      .clk      (clk),
      .rst      (rst),
      .start    (s1_start),
      .abort    (s1_abort),
      .in_valid (s1_valid),
      .in_data  (s1_data_in),
      .in_ready (s1_ready),
      .data     (s1_data),
      .sel_reg  (s1_sel),
      .busy     (s1_busy),
      .done     (s1_done)
   );

   // Bank model: entry k captures data on the edge that ends a sel_reg=k cycle
   logic [6:0] bank [0:7];
   always @(posedge clk) begin
      if (sel_reg != 3'd0) bank[sel_reg] <= data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
      s1_start = 1'b0; s1_abort = 1'b0; s1_valid = 1'b0; s1_data_in = '0;
      tick();
      tick();
      checks++;
      if ({data, sel_reg, done, busy, in_ready} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs: got data=%h sel=%0d done=%b busy=%b rdy=%b want all 0",
                  data, sel_reg, done, busy, in_ready);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({busy, in_ready, s1_busy, s1_ready} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b rdy=%b n1_busy=%b n1_rdy=%b want 0 0 0 0",
                  busy, in_ready, s1_busy, s1_ready);
      end
      $display("test_reset done");
   endtask

   task automatic test_full_load();
      start = 1'b1; in_valid = 1'b1; in_data = 7'h7F;   // word in IDLE must be ignored
      tick();
      start = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         checks++;
         if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_ready c%0d: got rdy=%b busy=%b want 1 1", c, in_ready, busy);
         end
         checks++;
         if (sel_reg !== 3'(c - 1) || data !== ((c == 1) ? 7'h00 : 7'(16 + c - 1))) begin
            errors++;
            $display("FAIL full_strobe c%0d: got sel=%0d data=%h want sel=%0d", c, sel_reg, data, c - 1);
         end
         in_data = 7'(16 + c);
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (sel_reg !== 3'd7 || data !== 7'h17 || in_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL full_last: got sel=%0d data=%h rdy=%b busy=%b done=%b want 7 17 0 1 0",
                  sel_reg, data, in_ready, busy, done);
      end
      tick();
      checks++;
      if (done !== 1'b1 || sel_reg !== 3'd0 || busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_done: got done=%b sel=%0d busy=%b rdy=%b want 1 0 1 0",
                  done, sel_reg, busy, in_ready);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL full_idle: got done=%b busy=%b want 0 0", done, busy);
      end
      for (int k = 1; k <= 7; k++) begin
         checks++;
         if (bank[k] !== 7'(16 + k)) begin
            errors++;
            $display("FAIL full_bank[%0d]: got %h want %h", k, bank[k], 7'(16 + k));
         end
      end
      $display("test_full_load done");
   endtask

   task automatic test_gap();
      int t2_valid [10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
      int t2_word  [10] = '{'h21, 'h22, 'h23, 'h7F, 'h7F, 'h7F, 'h24, 'h25, 'h26, 'h27};
      int t2_sel   [12] = '{0, 1, 2, 3, 0, 0, 0, 4, 5, 6, 7, 0};
      int t2_data  [12] = '{'h17, 'h21, 'h22, 'h23, 'h23, 'h23, 'h23, 'h24, 'h25, 'h26, 'h27, 'h27};
      int t2_done  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      start = 1'b1; in_valid = 1'b0;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         checks++;
         if (sel_reg !== 3'(t2_sel[c-1]) || data !== 7'(t2_data[c-1]) || done !== 1'(t2_done[c-1])) begin
            errors++;
            $display("FAIL gap_cycle c%0d: got sel=%0d data=%h done=%b want sel=%0d data=%h done=%0d",
                     c, sel_reg, data, done, t2_sel[c-1], t2_data[c-1], t2_done[c-1]);
         end
         checks++;
         if (in_ready !== (c <= 10)) begin
            errors++;
            $display("FAIL gap_ready c%0d: got %b want %b", c, in_ready, (c <= 10));
         end
         if (c <= 10) begin
            in_valid = 1'(t2_valid[c-1]);
            in_data  = 7'(t2_word[c-1]);
         end else begin
            in_valid = 1'b0;
         end
         tick();
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL gap_idle: got busy=%b want 0", busy);
      end
      for (int k = 1; k <= 7; k++) begin
         checks++;
         if (bank[k] !== 7'(32 + k)) begin
            errors++;
            $display("FAIL gap_bank[%0d]: got %h want %h", k, bank[k], 7'(32 + k));
         end
      end
      $display("test_gap done");
   endtask

   task automatic test_abort();
      start = 1'b1;
      tick();
      start = 1'b0; in_valid = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         in_data = 7'(48 + c);
         tick();
      end
      abort = 1'b1; in_data = 7'h35;
      #1;
      checks++;
      if (in_ready !== 1'b0 || sel_reg !== 3'd4 || data !== 7'h34 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_cycle: got rdy=%b sel=%0d data=%h busy=%b want 0 4 34 1",
                  in_ready, sel_reg, data, busy);
      end
      tick();
      abort = 1'b0; in_valid = 1'b0;
      checks++;
      if (busy !== 1'b0 || sel_reg !== 3'd0 || in_ready !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: got busy=%b sel=%0d rdy=%b done=%b want 0 0 0 0",
                  busy, sel_reg, in_ready, done);
      end
      tick();
      checks++;
      if (sel_reg !== 3'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_after: got sel=%0d done=%b want 0 0", sel_reg, done);
      end
      for (int k = 1; k <= 7; k++) begin
         checks++;
         if (bank[k] !== ((k <= 4) ? 7'(48 + k) : 7'(32 + k))) begin
            errors++;
            $display("FAIL abort_bank[%0d]: got %h want %h", k, bank[k],
                     (k <= 4) ? 7'(48 + k) : 7'(32 + k));
         end
      end
      $display("test_abort done");
   endtask

   task automatic test_rst_midload();
      start = 1'b1;
      tick();
      start = 1'b0; in_valid = 1'b1;
      for (int c = 1; c <= 2; c++) begin
         in_data = 7'(64 + c);
         tick();
      end
      rst = 1'b1; in_data = 7'h43;
      checks++;
      if (sel_reg !== 3'd2 || data !== 7'h42) begin
         errors++;
         $display("FAIL rst_pre: got sel=%0d data=%h want 2 42", sel_reg, data);
      end
      tick();
      rst = 1'b0; in_valid = 1'b0;
      checks++;
      if ({data, sel_reg, done, busy, in_ready} !== 13'd0) begin
         errors++;
         $display("FAIL rst_mid: got data=%h sel=%0d done=%b busy=%b rdy=%b want all 0",
                  data, sel_reg, done, busy, in_ready);
      end
      start = 1'b1;
      tick();
      start = 1'b0; in_valid = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         checks++;
         if (sel_reg !== 3'(c - 1) || data !== ((c == 1) ? 7'h00 : 7'(80 + c - 1))) begin
            errors++;
            $display("FAIL rst_reload c%0d: got sel=%0d data=%h want sel=%0d", c, sel_reg, data, c - 1);
         end
         in_data = 7'(80 + c);
         tick();
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL rst_reload_done: got %b want 1", done);
      end
      tick();
      for (int k = 1; k <= 7; k++) begin
         checks++;
         if (bank[k] !== 7'(80 + k)) begin
            errors++;
            $display("FAIL rst_bank[%0d]: got %h want %h", k, bank[k], 7'(80 + k));
         end
      end
      $display("test_rst_midload done");
   endtask

   task automatic test_start_ignored();
      int strobes   = 0;
      int dones     = 0;
      int done_at   = 0;
      start = 1'b1; in_valid = 1'b1; in_data = 7'h60;
      tick();
      for (int c = 1; c <= 9; c++) begin
         if (sel_reg != 3'd0) strobes++;
         if (done === 1'b1) begin
            dones++;
            done_at = c;
         end
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ign_busy c%0d: got %b want 1", c, busy);
         end
         in_data = 7'(96 + c);
         tick();
      end
      checks++;
      if (strobes !== 7 || dones !== 1 || done_at !== 9) begin
         errors++;
         $display("FAIL ign_counts: got strobes=%0d dones=%0d done_at=%0d want 7 1 9",
                  strobes, dones, done_at);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL ign_idle: got busy=%b done=%b want 0 0", busy, done);
      end
      abort = 1'b1;     // start together with abort in IDLE still starts
      tick();
      start = 1'b0; abort = 1'b0; in_data = 7'h6A;
      #1;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1 || sel_reg !== 3'd0) begin
         errors++;
         $display("FAIL ign_restart: got busy=%b rdy=%b sel=%0d want 1 1 0", busy, in_ready, sel_reg);
      end
      tick();
      checks++;
      if (sel_reg !== 3'd1 || data !== 7'h6A) begin
         errors++;
         $display("FAIL ign_first: got sel=%0d data=%h want 1 6a", sel_reg, data);
      end
      abort = 1'b1; in_valid = 1'b0;
      tick();
      abort = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL ign_end: got busy=%b done=%b want 0 0", busy, done);
      end
      $display("test_start_ignored done");
   endtask

   task automatic test_n1();
      s1_start = 1'b1; s1_valid = 1'b1; s1_data_in = 7'h5A;
      tick();
      s1_start = 1'b0;
      checks++;
      if (s1_ready !== 1'b1 || s1_sel !== 3'd0) begin
         errors++;
         $display("FAIL n1_load: got rdy=%b sel=%0d want 1 0", s1_ready, s1_sel);
      end
      tick();
      s1_data_in = 7'h33;
      checks++;
      if (s1_sel !== 3'd1 || s1_data !== 7'h5A || s1_ready !== 1'b0 || s1_done !== 1'b0) begin
         errors++;
         $display("FAIL n1_last: got sel=%0d data=%h rdy=%b done=%b want 1 5a 0 0",
                  s1_sel, s1_data, s1_ready, s1_done);
      end
      tick();
      s1_valid = 1'b0;
      checks++;
      if (s1_done !== 1'b1 || s1_sel !== 3'd0 || s1_busy !== 1'b1) begin
         errors++;
         $display("FAIL n1_done: got done=%b sel=%0d busy=%b want 1 0 1", s1_done, s1_sel, s1_busy);
      end
      tick();
      checks++;
      if (s1_done !== 1'b0 || s1_busy !== 1'b0) begin
         errors++;
         $display("FAIL n1_idle: got done=%b busy=%b want 0 0", s1_done, s1_busy);
      end
      $display("test_n1 done");
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_gap();
      test_abort();
      test_rst_midload();
      test_start_ignored();
      test_n1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
